// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    DONE
  } mult_state_t;

endpackage

// File: rtl/mult_fsm.sv
// Control for the shift-and-add multiplier: sequences IDLE/LOAD/CALC/DONE,
// counts iterations and produces registered busy/done plus datapath enables.
module mult_fsm
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mreg_rest_zero,
  output logic load_en,
  output logic calc_en,
  output logic cap_en,
  output logic busy,
  output logic done
);

  localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  mult_state_t     state;
  logic [CntW-1:0] cnt;
  logic            last_iter;

  // Final CALC pass: all bits consumed, or (early exit) nothing left to add.
  assign last_iter = (cnt == CntLast) || (EARLY_EXIT && mreg_rest_zero);

  // State, iteration count and registered busy/done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          state <= CALC;
          cnt   <= '0;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            state <= DONE;
          end
        end
        DONE: begin
          // done rises together with the product capture and busy falling.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load_en = (state == LOAD);
  assign calc_en = (state == CALC);
  assign cap_en  = (state == DONE);

endmodule

// File: rtl/seq_shift_multiplier.sv
// Iterative unsigned shift-and-add multiplier, one multiplier bit per clock.
module seq_shift_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mreg;
  logic               load_en;
  logic               calc_en;
  logic               cap_en;
  logic               mreg_rest_zero;

  // Multiplier bits still to be consumed after this cycle's shift.
  assign mreg_rest_zero = ((mreg >> 1) == '0);

  mult_fsm #(
    .WIDTH      (WIDTH),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_fsm (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mreg_rest_zero (mreg_rest_zero),
    .load_en        (load_en),
    .calc_en        (calc_en),
    .cap_en         (cap_en),
    .busy           (busy),
    .done           (done)
  );

  // Operand capture and per-cycle conditional add / shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mreg  <= '0;
    end else if (load_en) begin
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, multiplicand};
      mreg  <= multiplier;
    end else if (calc_en) begin
      if (mreg[0]) begin
        acc <= acc + mcand;
      end
      mcand <= mcand << 1;
      mreg  <= mreg >> 1;
    end
  end

  // Product only updates with a finished sum, never a partial one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
    end else if (cap_en) begin
      product <= acc;
    end
  end

endmodule

// File: tb/tb_seq_shift_multiplier.sv
// Self-checking bench: fixed-latency and early-exit instances driven in parallel.
module tb_seq_shift_multiplier;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          busy, done, busy_ee, done_ee;
  logic [2*W-1:0] product, product_ee;

  int n_assert;
  int n_fail;
  logic [31:0] prev0, prev1;

  seq_shift_multiplier #(
    .WIDTH      (W),
    .EARLY_EXIT (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  seq_shift_multiplier #(
    .WIDTH      (W),
    .EARLY_EXIT (1'b1)
  ) dut_ee (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy_ee),
    .done         (done_ee),
    .product      (product_ee)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Early-exit latency: 3 plus the index of B's highest set bit (3 for B=0).
  function automatic int ee_lat(input logic [15:0] b);
    if (b == 16'd0) return 3;
    return 2 + $clog2(int'(b) + 1);
  endfunction

  // One operation on both instances; called and returns one step after a rising edge.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int glitch_at);
    logic [31:0] expp;
    logic [31:0] prod_at0, prod_at1;
    int exp_lat1, lat0, lat1, pulses0, pulses1, busy0, busy1;
    expp     = 32'(a) * 32'(b);
    exp_lat1 = ee_lat(b);
    lat0 = 0; lat1 = 0; pulses0 = 0; pulses1 = 0; busy0 = 0; busy1 = 0;
    prod_at0 = '0; prod_at1 = '0;
    start = 1'b1; multiplicand = a; multiplier = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= int'(W) + 5; c++) begin
      if (busy) busy0++;
      if (busy_ee) busy1++;
      if (c == glitch_at) begin
        start = 1'b1; multiplicand = 16'd2; multiplier = 16'd2;
      end
      @(posedge clk); #1;
      if (c == glitch_at) start = 1'b0;
      if (c == int'(W) + 1) chk({tag, ":hold"}, 64'(product), 64'(prev0));
      if (c == exp_lat1 - 1) chk({tag, ":hold_ee"}, 64'(product_ee), 64'(prev1));
      if (done) begin
        pulses0++;
        if (lat0 == 0) begin lat0 = c; prod_at0 = product; end
      end
      if (done_ee) begin
        pulses1++;
        if (lat1 == 0) begin lat1 = c; prod_at1 = product_ee; end
      end
    end
    chk({tag, ":lat"},      64'(lat0),     64'(W + 2));
    chk({tag, ":lat_ee"},   64'(lat1),     64'(exp_lat1));
    chk({tag, ":pulses"},   64'(pulses0),  64'd1);
    chk({tag, ":pulses_ee"},64'(pulses1),  64'd1);
    chk({tag, ":busy"},     64'(busy0),    64'(W + 2));
    chk({tag, ":busy_ee"},  64'(busy1),    64'(exp_lat1));
    chk({tag, ":prod"},     64'(prod_at0), 64'(expp));
    chk({tag, ":prod_ee"},  64'(prod_at1), 64'(expp));
    chk({tag, ":held"},     64'(product),  64'(expp));
    chk({tag, ":held_ee"},  64'(product_ee), 64'(expp));
    prev0 = expp;
    prev1 = expp;
  endtask

  initial begin
    logic [15:0] a_cur, b_cur, a_nxt, b_nxt, ra, rb;
    int pulses0, pulses1;
    n_assert = 0; n_fail = 0; prev0 = '0; prev1 = '0;
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", 64'(product), 64'd0);
    chk("rst_busy_ee", 64'(busy_ee), 64'd0);
    chk("rst_done_ee", 64'(done_ee), 64'd0);
    chk("rst_prod_ee", 64'(product_ee), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op("t1_3x5",     16'h0003, 16'h0005, 0);
    run_op("t2_ffxff",   16'hFFFF, 16'hFFFF, 0);
    run_op("t3_bzero",   16'h1234, 16'h0000, 0);
    run_op("a_zero",     16'h0000, 16'hFFFF, 0);
    run_op("b_msb",      16'hABCD, 16'h8000, 0);
    run_op("t4_glitch",  16'd7,    16'd9,    5);

    // Asynchronous reset mid-operation
    start = 1'b1; multiplicand = 16'h00FF; multiplier = 16'h0101;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_prod", 64'(product), 64'd0);
    chk("t5_busy_ee", 64'(busy_ee), 64'd0);
    chk("t5_prod_ee", 64'(product_ee), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses0 = 0; pulses1 = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done) pulses0++;
      if (done_ee) pulses1++;
    end
    chk("t5_no_done", 64'(pulses0), 64'd0);
    chk("t5_no_done_ee", 64'(pulses1), 64'd0);
    prev0 = '0; prev1 = '0;
    run_op("t5_after", 16'd2, 16'd3, 0);

    // Random single operations on both instances
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
      run_op("rand", ra, rb, 0);
    end

    // Back-to-back with start held high (fixed-latency instance)
    start = 1'b1;
    a_cur = 16'($urandom); b_cur = 16'($urandom);
    multiplicand = a_cur; multiplier = b_cur;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      a_nxt = 16'($urandom); b_nxt = 16'($urandom);
      multiplicand = a_nxt; multiplier = b_nxt;
      repeat (W) @(posedge clk);
      #1;
      chk("b2b_pre", 64'(done), 64'd0);
      @(posedge clk); #1;
      chk("b2b_done", 64'(done), 64'd1);
      chk("b2b_prod", 64'(product), 64'(32'(a_cur) * 32'(b_cur)));
      a_cur = a_nxt; b_cur = b_nxt;
    end
    start = 1'b0;
    repeat (30) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
